// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming layout helpers for hamming_enc_pipe and hamming_dec.
// Codeword positions: 0 = overall parity, powers of two = Hamming parity.
package hamming_pkg;

    localparam int MAX_POS = 64;

    function automatic int calc_m(input int k);
        int m;
        m = 0;
        for (int i = 1; i < 16; i++) begin
            if (m == 0 && (1 << i) >= i + k + 1) begin
                m = i;
            end
        end
        return m;
    endfunction

    function automatic bit is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Codeword position of data bit j: the j-th non-power-of-two index >= 1.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < MAX_POS; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic bit covers(input int pos, input int p);
        return ((pos >> p) & 1) == 1;
    endfunction

    // Data-bit mask feeding Hamming parity bit p (position 2**p).
    function automatic logic [MAX_POS-1:0] par_mask(input int p, input int k);
        logic [MAX_POS-1:0] mask;
        mask = '0;
        for (int j = 0; j < MAX_POS; j++) begin
            if (j < k && covers(data_pos(j), p)) begin
                mask = mask | (64'd1 << j);
            end
        end
        return mask;
    endfunction

    // Output bit index of codeword position pos for the chosen parity placement.
    function automatic int out_idx(input int pos, input int n, input bit p0_lsb);
        if (p0_lsb) begin
            return pos;
        end
        return (pos == 0) ? n : pos - 1;
    endfunction

endpackage

// File: rtl/hamming_pipe_stage.sv
// One valid/ready register slice; advances when empty or when downstream takes.
// Payload is cleared on reset so an idle output reads as zero.
module hamming_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/hamming_enc_pipe.sv
// Two-stage pipelined SECDED Hamming encoder with valid/ready handshake.
// Define HAMMING_ENC_ERR_INJ_EN to add the inj_en_i/inj_mask_i error injection ports.
module hamming_enc_pipe
    import hamming_pkg::*;
#(
    parameter int K      = 8,
    parameter bit P0_LSB = 1'b1,
    parameter int M      = calc_m(K),
    parameter int N      = M + K
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [K-1:0] d_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N:0]   q_o,
`ifdef HAMMING_ENC_ERR_INJ_EN
    input  logic         inj_en_i,
    input  logic [N:0]   inj_mask_i,
`endif
    output logic [15:0]  cnt_o
);

`ifdef HAMMING_ENC_ERR_INJ_EN
    localparam int W1 = K + M + N + 2;
`else
    localparam int W1 = K + M;
`endif

    logic [M-1:0]  par;
    logic [W1-1:0] s1_in;
    logic [W1-1:0] s1_q;
    logic          s1_vld;
    logic          s1_rdy;
    logic [K-1:0]  s1_d;
    logic [M-1:0]  s1_par;
    logic [N:1]    cw_hi;
    logic [N:0]    cw;
    logic [N:0]    s2_pre;
    logic [N:0]    s2_in;
    logic [15:0]   cnt;

    for (genvar p = 0; p < M; p++) begin : g_par
        localparam logic [MAX_POS-1:0] PM = par_mask(p, K);
        assign par[p] = ^(d_i & PM[K-1:0]);
    end

`ifdef HAMMING_ENC_ERR_INJ_EN
    assign s1_in = {inj_en_i, inj_mask_i, par, d_i};
`else
    assign s1_in = {par, d_i};
`endif

    hamming_pipe_stage #(.W(W1)) u_s1 (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .up_valid (valid_i),
        .up_ready (ready_o),
        .up_data  (s1_in),
        .dn_valid (s1_vld),
        .dn_ready (s1_rdy),
        .dn_data  (s1_q)
    );

    assign s1_d   = s1_q[K-1:0];
    assign s1_par = s1_q[K+M-1:K];

    for (genvar j = 0; j < K; j++) begin : g_dat
        localparam int P = data_pos(j);
        assign cw_hi[P] = s1_d[j];
    end

    for (genvar p = 0; p < M; p++) begin : g_pbit
        assign cw_hi[1 << p] = s1_par[p];
    end

    assign cw = {cw_hi, ^cw_hi};

    for (genvar i = 0; i <= N; i++) begin : g_map
        localparam int O = out_idx(i, N, P0_LSB);
        assign s2_pre[O] = cw[i];
    end

    // Injection mask is applied in q_o bit order, after parity generation.
`ifdef HAMMING_ENC_ERR_INJ_EN
    assign s2_in = s1_q[W1-1] ? (s2_pre ^ s1_q[K+M+N:K+M]) : s2_pre;
`else
    assign s2_in = s2_pre;
`endif

    hamming_pipe_stage #(.W(N + 1)) u_s2 (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .up_valid (s1_vld),
        .up_ready (s1_rdy),
        .up_data  (s2_in),
        .dn_valid (valid_o),
        .dn_ready (ready_i),
        .dn_data  (q_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (valid_o && ready_i && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign cnt_o = cnt;

endmodule

// File: tb/tb_hamming_enc_pipe.sv
// Self-checking bench for hamming_enc_pipe (K=8) with both parity placements.
// Reference codec is built from syndrome arithmetic, independent of the RTL.
module tb_hamming_enc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [7:0]  d_i = 8'h00;
    logic        ready_o, valid_o, ready0, valid0;
    logic [12:0] q_o, q0;
    logic [15:0] cnt_o, cnt0;
`ifdef HAMMING_ENC_ERR_INJ_EN
    logic        inj_en = 1'b0;
    logic [12:0] inj_mask = 13'h0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_enc_pipe #(.K(8), .P0_LSB(1'b1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .d_i        (d_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .q_o        (q_o),
`ifdef HAMMING_ENC_ERR_INJ_EN
        .inj_en_i   (inj_en),
        .inj_mask_i (inj_mask),
`endif
        .cnt_o      (cnt_o)
    );

    hamming_enc_pipe #(.K(8), .P0_LSB(1'b0)) dut0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready0),
        .d_i        (d_i),
        .valid_o    (valid0),
        .ready_i    (ready_i),
        .q_o        (q0),
`ifdef HAMMING_ENC_ERR_INJ_EN
        .inj_en_i   (inj_en),
        .inj_mask_i (inj_mask),
`endif
        .cnt_o      (cnt0)
    );

    // Parity bits are chosen so the XOR of all set positions is zero.
    function automatic logic [12:0] ref_enc(input logic [7:0] d, input bit p0lsb);
        logic [12:0] cw;
        int j;
        int syn;
        cw = '0;
        j = 0;
        syn = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[j];
                if (d[j]) syn = syn ^ pos;
                j++;
            end
        end
        for (int b = 0; b < 4; b++) cw[1 << b] = syn[b];
        cw[0] = ^cw[12:1];
        return p0lsb ? cw : {cw[0], cw[12:1]};
    endfunction

    // Returns {sb_err, db_err, corrected data}.
    function automatic logic [9:0] ref_dec(input logic [12:0] q, input bit p0lsb);
        logic [12:0] cw;
        logic [7:0]  d;
        logic        par, sb, db;
        int syn;
        int j;
        cw = p0lsb ? q : {q[11:0], q[12]};
        syn = 0;
        for (int pos = 1; pos <= 12; pos++) if (cw[pos]) syn = syn ^ pos;
        par = ^cw;
        sb = par;
        db = !par && (syn != 0);
        if (par && syn > 0 && syn <= 12) cw[syn] = ~cw[syn];
        j = 0;
        d = '0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos];
                j++;
            end
        end
        return {sb, db, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] d, input logic [12:0] e1, input logic [12:0] e0);
        valid_i = 1'b1;
        d_i = d;
        #1 chk("send_ready", ready_o, 1);
        tick();
        valid_i = 1'b0;
        #1 chk("lat1_valid", valid_o, 0);
        tick();
        chk("lat2_valid", valid_o, 1);
        chk("lat2_q_p0lsb", q_o, e1);
        chk("lat2_q_p0msb", q0, e0);
        tick();
        chk("after_valid", valid_o, 0);
    endtask

    logic [7:0]  w0, w1, w2, e;
    logic [9:0]  dec;
    logic [12:0] prev_q;
    logic        prev_stall;
    int          sent, rcvd, cyc;
    logic [7:0]  exp_q[$];

    initial begin
        ready_i = 1'b1;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_q", q_o, 0);
        chk("rst_ready", ready_o, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        send1(8'h00, 13'h0000, 13'h0000);
        send1(8'h01, 13'h000F, 13'h1007);
        send1(8'hFF, 13'h1EEE, 13'h0F77);
        for (int i = 0; i < 4; i++) begin
            w0 = 8'($urandom);
            send1(w0, ref_enc(w0, 1'b1), ref_enc(w0, 1'b0));
        end
        chk("cnt_directed", cnt_o, 7);

        ready_i = 1'b0;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        valid_i = 1'b1;
        d_i = w0;
        #1 chk("bp_ready0", ready_o, 1);
        tick();
        d_i = w1;
        #1 chk("bp_ready1", ready_o, 1);
        tick();
        d_i = w2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_full_ready", ready_o, 0);
            chk("bp_full_valid", valid_o, 1);
            chk("bp_full_q", q_o, ref_enc(w0, 1'b1));
            tick();
        end
        ready_i = 1'b1;
        #1 chk("bp_release_ready", ready_o, 1);
        chk("bp_q0", q_o, ref_enc(w0, 1'b1));
        tick();
        valid_i = 1'b0;
        #1 chk("bp_valid1", valid_o, 1);
        chk("bp_q1", q_o, ref_enc(w1, 1'b1));
        tick();
        chk("bp_q2", q_o, ref_enc(w2, 1'b1));
        tick();
        chk("bp_drained", valid_o, 0);
        chk("cnt_bp", cnt_o, 10);

        ready_i = 1'b0;
        valid_i = 1'b1;
        d_i = 8'($urandom);
        tick();
        d_i = 8'($urandom);
        tick();
        valid_i = 1'b0;
        #1;
        chk("full_valid", valid_o, 1);
        chk("full_ready", ready_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_cnt", cnt_o, 0);
        chk("async_rst_q", q_o, 0);
        chk("async_rst_ready", ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("no_stale0", valid_o, 0);
        tick();
        chk("no_stale1", valid_o, 0);
        w0 = 8'($urandom);
        send1(w0, ref_enc(w0, 1'b1), ref_enc(w0, 1'b0));

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sent = 0;
        rcvd = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_q = '0;
        while (rcvd < 256 && cyc < 4000) begin
            ready_i = 1'($urandom_range(0, 1));
            valid_i = (sent < 256);
            d_i = sent[7:0];
            #1;
            if (prev_stall) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_q", q_o, prev_q);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_emit", valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_q", q_o, ref_enc(e, 1'b1));
                    chk("stream_q0", q0, ref_enc(e, 1'b0));
                    dec = ref_dec(q_o, 1'b1);
                    chk("stream_dec_data", dec[7:0], e);
                    chk("stream_dec_err", dec[9:8], 0);
                    dec = ref_dec(q0, 1'b0);
                    chk("stream_dec0_data", dec[7:0], e);
                    chk("stream_dec0_err", dec[9:8], 0);
                end
                rcvd++;
            end
            prev_stall = valid_o && !ready_i;
            prev_q = q_o;
            if (valid_i && ready_o) begin
                exp_q.push_back(d_i);
                sent++;
            end
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("stream_rcvd", rcvd, 256);
        chk("stream_leftover", exp_q.size(), 0);
        chk("stream_cnt", cnt_o, 256);

`ifdef HAMMING_ENC_ERR_INJ_EN
        inj_en = 1'b1;
        inj_mask = 13'h0008;
        valid_i = 1'b1;
        d_i = 8'hA5;
        tick();
        valid_i = 1'b0;
        inj_en = 1'b0;
        tick();
        chk("inj1_valid", valid_o, 1);
        dec = ref_dec(q_o, 1'b1);
        chk("inj1_sb", dec[9], 1);
        chk("inj1_db", dec[8], 0);
        chk("inj1_data", dec[7:0], 8'hA5);
        tick();
        inj_en = 1'b1;
        inj_mask = 13'h0018;
        valid_i = 1'b1;
        d_i = 8'hA5;
        tick();
        valid_i = 1'b0;
        inj_en = 1'b0;
        tick();
        chk("inj2_valid", valid_o, 1);
        dec = ref_dec(q_o, 1'b1);
        chk("inj2_db", dec[8], 1);
        chk("inj2_sb", dec[9], 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
